// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a CPU pipeline port and a DMA loader port onto one
// single-port data memory. CPU has priority; a starved DMA port is forced in and
// then keeps the memory for a bounded burst.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned WORDS        = 103
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,

    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,

    output logic        err
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned BW = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(BURST_LEN);

    typedef enum logic [0:0] {StCpuPri, StDmaBurst} state_t;

    state_t        r_state;
    logic [SW-1:0] r_starve_cnt;
    logic [BW-1:0] r_burst_cnt;
    logic          r_cpu_rvalid;
    logic [31:0]   r_cpu_rdata;
    logic          r_dma_rvalid;
    logic [31:0]   r_dma_rdata;
    logic          r_err;

    logic          w_cpu_gnt;
    logic          w_dma_gnt;
    logic          w_cpu_oor;
    logic          w_dma_oor;
    logic [BW-1:0] w_burst_inc;

    // Out-of-range: upper address bits set or word index beyond the memory depth.
    always_comb begin
        w_cpu_oor = (cpu_addr[31:14] != 18'd0) || (32'(cpu_addr[13:2]) >= WORDS);
        w_dma_oor = (dma_addr[31:14] != 18'd0) || (32'(dma_addr[13:2]) >= WORDS);
    end

    // Grant decision; a burst with dma_req dropped falls back to CPU-priority rules.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!reset) begin
            if (r_state == StDmaBurst && dma_req) begin
                w_dma_gnt = 1'b1;
            end else if (dma_req && (r_starve_cnt == STARVE_MAX || !cpu_req)) begin
                w_dma_gnt = 1'b1;
            end else if (cpu_req) begin
                w_cpu_gnt = 1'b1;
            end
        end
    end

    // Burst length after the current DMA grant (a grant from CPU_PRI opens a new burst).
    always_comb begin
        w_burst_inc = (r_state == StDmaBurst) ? r_burst_cnt + BW'(1) : BW'(1);
    end

    // Memory port mux from the granted side; writes out of range are suppressed.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = 32'd0;
        mem_wd = 32'd0;
        if (w_cpu_gnt) begin
            mem_we = cpu_we & ~w_cpu_oor;
            mem_a  = cpu_addr;
            mem_wd = cpu_wdata;
        end else if (w_dma_gnt) begin
            mem_we = dma_we & ~w_dma_oor;
            mem_a  = dma_addr;
            mem_wd = dma_wdata;
        end
    end

    // Arbiter FSM with starvation and burst counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StCpuPri;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
        end else begin
            if (w_dma_gnt && w_burst_inc < BURST_MAX) begin
                r_state     <= StDmaBurst;
                r_burst_cnt <= w_burst_inc;
            end else begin
                r_state     <= StCpuPri;
                r_burst_cnt <= '0;
            end

            if (!dma_req || w_dma_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end

    // Read return and error flag, one cycle after the granting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= 32'd0;
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
            if (w_cpu_gnt && !cpu_we) begin
                r_cpu_rdata <= w_cpu_oor ? 32'd0 : mem_rd;
            end
            r_dma_rvalid <= w_dma_gnt & ~dma_we;
            if (w_dma_gnt && !dma_we) begin
                r_dma_rdata <= w_dma_oor ? 32'd0 : mem_rd;
            end
            r_err <= (w_cpu_gnt & w_cpu_oor) | (w_dma_gnt & w_dma_oor);
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dma_gnt    = w_dma_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign dma_rvalid = r_dma_rvalid;
    assign dma_rdata  = r_dma_rdata;
    assign err        = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with a read-data scoreboard.
module tb_dmem_arbiter;

    localparam int WORDS = 103;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram    [0:WORDS-1];
    logic [31:0] shadow [0:WORDS-1];
    logic [31:0] cpu_q[$];
    logic [31:0] dma_q[$];
    logic [31:0] mon_exp;

    dmem_arbiter #(
        .STARVE_LIMIT(4),
        .BURST_LEN   (8),
        .WORDS       (WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rdata (dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: combinational read, write at the clock edge; garbage when out of range.
    always_comb begin
        mem_rd = 32'hDEAD_BEEF;
        if (mem_a[31:14] == 18'd0 && int'(mem_a[13:2]) < WORDS) mem_rd = ram[int'(mem_a[13:2])];
    end

    always @(posedge clk) begin
        if (mem_we && mem_a[31:14] == 18'd0 && int'(mem_a[13:2]) < WORDS)
            ram[int'(mem_a[13:2])] <= mem_wd;
    end

    // Scoreboard: every rvalid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1) begin
            n_checks++;
            if (cpu_q.size() == 0) begin
                n_fail++;
                $display("FAIL cpu_rvalid_unexpected: got rdata %08h, no read outstanding", cpu_rdata);
            end else begin
                mon_exp = cpu_q.pop_front();
                if (cpu_rdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL cpu_rdata_sb: got %08h expected %08h", cpu_rdata, mon_exp);
                end
            end
        end
        if (dma_rvalid === 1'b1) begin
            n_checks++;
            if (dma_q.size() == 0) begin
                n_fail++;
                $display("FAIL dma_rvalid_unexpected: got rdata %08h, no read outstanding", dma_rdata);
            end else begin
                mon_exp = dma_q.pop_front();
                if (dma_rdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL dma_rdata_sb: got %08h expected %08h", dma_rdata, mon_exp);
                end
            end
        end
    end

    function automatic bit in_rng(input logic [31:0] a);
        return (a[31:14] == 18'd0) && (int'(a[13:2]) < WORDS);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return in_rng(a) ? shadow[int'(a[13:2])] : 32'd0;
    endfunction

    // Record an access the bench expects to be granted this cycle.
    task automatic note_access(input bit is_cpu, input logic we, input logic [31:0] a,
                               input logic [31:0] d);
        if (!we) begin
            if (is_cpu) cpu_q.push_back(model_rd(a));
            else        dma_q.push_back(model_rd(a));
        end else if (in_rng(a)) begin
            shadow[int'(a[13:2])] = d;
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 1, 32'h8, 32'h1234, 1, 1, 32'h4, 32'h5678);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, dma_gnt, mem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_grants: got %b expected 000", {cpu_gnt, dma_gnt, mem_we});
        end
        n_checks++;
        if ({cpu_rvalid, dma_rvalid, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {cpu_rvalid, dma_rvalid, err});
        end
        n_checks++;
        if (cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %08h/%08h expected 0/0", cpu_rdata, dma_rdata);
        end
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_cpu_read();
        drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
        note_access(1, 0, 32'h8, 0);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, dma_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL cpu_read_gnt: got %b expected 10", {cpu_gnt, dma_gnt});
        end
        n_checks++;
        if (mem_a !== 32'h8 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_read_mux: got a=%08h we=%b expected a=00000008 we=0", mem_a, mem_we);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL cpu_read_data: got v=%b d=%08h expected v=1 d=cafe0001",
                     cpu_rvalid, cpu_rdata);
        end
        n_checks++;
        if ({mem_we, mem_a, mem_wd} !== 65'd0) begin
            n_fail++;
            $display("FAIL idle_mux: got we=%b a=%08h wd=%08h expected all 0", mem_we, mem_a, mem_wd);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL cpu_read_hold: got v=%b d=%08h expected v=0 d=cafe0001",
                     cpu_rvalid, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_dma_write();
        drive(0, 0, 0, 0, 1, 1, 32'h40, 32'h5A5A_0010);
        note_access(0, 1, 32'h40, 32'h5A5A_0010);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, dma_gnt, mem_we} !== 3'b011 || mem_a !== 32'h40 || mem_wd !== 32'h5A5A_0010) begin
            n_fail++;
            $display("FAIL dma_write_mux: got g=%b we=%b a=%08h wd=%08h expected g=01 we=1 a=40 wd=5a5a0010",
                     {cpu_gnt, dma_gnt}, mem_we, mem_a, mem_wd);
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 32'h40, 0);
        note_access(0, 0, 32'h40, 0);
        @(negedge clk);
        n_checks++;
        if (dma_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL dma_read_gnt: got %b expected 1", dma_gnt);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL dma_read_rvalid: got dma=%b cpu=%b expected dma=1 cpu=0",
                     dma_rvalid, cpu_rvalid);
        end
        next_cycle();
    endtask

    // Both ports requesting every cycle: 4 CPU grants then an 8-grant DMA burst, repeating.
    task automatic test_starve();
        bit exp_cpu;
        for (int k = 0; k < 24; k++) begin
            exp_cpu = (k % 12) < 4;
            drive(1, 0, 32'(k * 4), 0, 1, 0, 32'(32'h100 + k * 4), 0);
            if (exp_cpu) note_access(1, 0, 32'(k * 4), 0);
            else         note_access(0, 0, 32'(32'h100 + k * 4), 0);
            @(negedge clk);
            n_checks++;
            if (cpu_gnt !== exp_cpu || dma_gnt !== !exp_cpu) begin
                n_fail++;
                $display("FAIL starve_pattern[%0d]: got cpu=%b dma=%b expected cpu=%b dma=%b",
                         k, cpu_gnt, dma_gnt, exp_cpu, !exp_cpu);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_burst_drop();
        drive(0, 0, 0, 0, 1, 1, 32'h0, 32'h11);
        note_access(0, 1, 32'h0, 32'h11);
        @(negedge clk);
        n_checks++;
        if (dma_gnt !== 1'b1 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_w0: got gnt=%b we=%b expected 1/1", dma_gnt, mem_we);
        end
        next_cycle();
        drive(1, 0, 32'h4, 0, 1, 1, 32'h4, 32'h22);
        note_access(0, 1, 32'h4, 32'h22);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, dma_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_w1_burst: got %b expected 01", {cpu_gnt, dma_gnt});
        end
        next_cycle();
        drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
        note_access(1, 0, 32'h4, 0);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, dma_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL drop_cpu_gnt: got %b expected 10", {cpu_gnt, dma_gnt});
        end
        next_cycle();
        drive(1, 0, 32'h0, 0, 1, 0, 32'h8, 0);
        note_access(1, 0, 32'h0, 0);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, dma_gnt} !== 2'b10 || cpu_rdata !== 32'h22) begin
            n_fail++;
            $display("FAIL drop_cpu_pri: got g=%b d=%08h expected g=10 d=00000022",
                     {cpu_gnt, dma_gnt}, cpu_rdata);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (cpu_rdata !== 32'h11) begin
            n_fail++;
            $display("FAIL drop_rd0: got %08h expected 00000011", cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_out_of_range();
        drive(1, 1, 32'h19C, 32'hFFFF, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_write: got gnt=%b we=%b expected 1/0", cpu_gnt, mem_we);
        end
        next_cycle();
        drive(1, 1, 32'h198, 32'h77, 0, 0, 0, 0);
        note_access(1, 1, 32'h198, 32'h77);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_err_last_word: got err=%b we=%b expected 1/1", err, mem_we);
        end
        next_cycle();
        drive(1, 0, 32'h4008, 0, 0, 0, 0, 0);
        note_access(1, 0, 32'h4008, 0);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || cpu_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_hibits_gnt: got err=%b gnt=%b expected 0/1", err, cpu_gnt);
        end
        next_cycle();
        drive(1, 0, 32'h198, 0, 0, 0, 0, 0);
        note_access(1, 0, 32'h198, 0);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || cpu_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL oor_read: got err=%b d=%08h expected 1/0", err, cpu_rdata);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || cpu_rdata !== 32'h77) begin
            n_fail++;
            $display("FAIL oor_last_word_rd: got err=%b d=%08h expected 0/00000077", err, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_burst();
        bit exp_cpu;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1, 0, 32'(32'h20 + k * 4), 0);
            note_access(0, 0, 32'(32'h20 + k * 4), 0);
            @(negedge clk);
            n_checks++;
            if (dma_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL rb_burst[%0d]: got %b expected 1", k, dma_gnt);
            end
            next_cycle();
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 32'h30, 0);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, dma_gnt, mem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL rb_reset_gnt: got %b expected 000", {cpu_gnt, dma_gnt, mem_we});
        end
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, dma_rvalid, err} !== 3'b000 || cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rb_after_reset: got v=%b%b e=%b d=%08h/%08h expected 000 0/0",
                     cpu_rvalid, dma_rvalid, err, cpu_rdata, dma_rdata);
        end
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            exp_cpu = k < 4;
            drive(1, 0, 32'(32'h50 + k * 4), 0, 1, 0, 32'(32'h80 + k * 4), 0);
            if (exp_cpu) note_access(1, 0, 32'(32'h50 + k * 4), 0);
            else         note_access(0, 0, 32'(32'h80 + k * 4), 0);
            @(negedge clk);
            n_checks++;
            if (cpu_gnt !== exp_cpu || dma_gnt !== !exp_cpu) begin
                n_fail++;
                $display("FAIL rb_restart[%0d]: got cpu=%b dma=%b expected cpu=%b",
                         k, cpu_gnt, dma_gnt, exp_cpu);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram[i]    = 32'hA500_0000 | 32'(i);
            shadow[i] = 32'hA500_0000 | 32'(i);
        end
        ram[2]    = 32'hCAFE0001;
        shadow[2] = 32'hCAFE0001;

        test_reset();
        test_cpu_read();
        test_dma_write();
        test_starve();
        test_burst_drop();
        test_out_of_range();
        test_reset_burst();

        n_checks++;
        if (cpu_q.size() != 0 || dma_q.size() != 0) begin
            n_fail++;
            $display("FAIL reads_outstanding: got cpu=%0d dma=%0d expected 0/0",
                     cpu_q.size(), dma_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
